// File: rtl/spi_config_master.sv
// SPI mode-0 master that streams a configuration image from a synchronous byte store,
// highest address first and MSB first, while assembling MISO into readback bytes.
module spi_config_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              system_clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SS,
  input  logic              MISO
);

  localparam int unsigned HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [2:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] byte_q, byte_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              mosi_q, mosi_d;
  logic              sclk_q, sclk_d;
  logic              ss_q, ss_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hp_last;
  logic              enter_high;
  logic [7:0]        nxt_byte;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_pend_d  = rd_en_q;
    mosi_d     = mosi_q;
    enter_high = 1'b0;
    hp_last    = (hp_q == HP_LAST);
    // With CLK_DIV==2 the prefetched byte arrives in the same cycle it is needed
    nxt_byte   = rd_pend_q ? rd_data : hold_q;
    if (rd_pend_q) hold_d = rd_data;

    unique case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          state_d   = S_LOAD;
          rd_en_d   = 1'b1;
          rd_addr_d = len - ADDR_W'(1);
          byte_d    = len - ADDR_W'(1);
        end
      end
      S_LOAD: begin
        state_d = S_SETUP;
        hp_d    = '0;
        bit_d   = 3'd7;
      end
      S_SETUP: begin
        if (rd_pend_q) begin
          tx_d   = rd_data;
          mosi_d = rd_data[7];
        end
        if (hp_last) begin
          state_d    = S_HIGH;
          hp_d       = '0;
          enter_high = 1'b1;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      S_HIGH: begin
        if (hp_q == '0) begin
          rx_sr_d = {rx_sr_q[6:0], MISO};
          if (bit_q == 3'd0) begin
            rx_valid_d = 1'b1;
            rx_data_d  = {rx_sr_q[6:0], MISO};
          end
        end
        if (hp_last) begin
          hp_d = '0;
          if (bit_q != 3'd0) begin
            state_d = S_LOW;
            bit_d   = bit_q - 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
          end else if (byte_q != '0) begin
            state_d = S_LOW;
            bit_d   = 3'd7;
            byte_d  = byte_q - ADDR_W'(1);
            tx_d    = nxt_byte;
            mosi_d  = nxt_byte[7];
          end else begin
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      S_LOW: begin
        if (hp_last) begin
          state_d    = S_HIGH;
          hp_d       = '0;
          enter_high = 1'b1;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      S_HOLD: begin
        if (hp_last) begin
          state_d = S_DONE;
          hp_d    = '0;
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Prefetch the next byte while its predecessor's last bit is high
    if (enter_high && (bit_q == 3'd0) && (byte_q != '0)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = byte_q - ADDR_W'(1);
    end

    sclk_d = (state_d == S_HIGH);
    ss_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge system_clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      hp_q       <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_pend_q  <= 1'b0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend_q  <= rd_pend_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SS       = ss_q;

endmodule

// File: tb/tb_spi_config_master.sv
// Directed bench for spi_config_master: byte store model plus a mode-0 slave monitor.
module tb_spi_config_master;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned CLK_DIV = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data = '0;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              busy;
  logic              done;
  logic              SCLK;
  logic              MOSI;
  logic              SS;
  logic              MISO = 1'b0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  spi_config_master #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .system_clock(clk), .reset(reset), .start(start), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO)
  );

  logic [7:0] mem [256];

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Slave-side observer: values sampled here are those of the cycle just ended
  int cyc = 0, busy_cycles = 0, done_cnt = 0, rden_cnt = 0;
  int period_bad = 0, ss_bad = 0, rxv_bad = 0, last_rise = -1, bitn = 0;
  logic [7:0] mosi_sr = '0;
  logic [7:0] tx_bytes [$];
  logic [7:0] rx_bytes [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic sclk_prev = 1'b0, ss_prev = 1'b1;
  logic [7:0] miso_pat = '0;
  logic [2:0] miso_idx = 3'd7;

  always @(posedge clk) begin
    cyc++;
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (rd_en) begin rden_cnt++; addr_q.push_back(rd_addr); end
    if (rx_valid) begin
      rx_bytes.push_back(rx_data);
      if (cyc - last_rise != 1) rxv_bad++;
    end
    if (SCLK && !sclk_prev) begin
      if (SS !== 1'b0) ss_bad++;
      if (last_rise >= 0 && (cyc - last_rise) != int'(2 * CLK_DIV)) period_bad++;
      last_rise = cyc;
      mosi_sr = {mosi_sr[6:0], MOSI};
      bitn++;
      if (bitn == 8) begin tx_bytes.push_back(mosi_sr); bitn = 0; end
    end
    if (!SS && ss_prev) begin
      miso_idx = 3'd7;
      MISO = miso_pat[7];
    end else if (!SCLK && sclk_prev && !SS) begin
      miso_idx = miso_idx - 3'd1;
      MISO = miso_pat[miso_idx];
    end
    sclk_prev = SCLK;
    ss_prev = SS;
  end

  task automatic clear_mon();
    @(negedge clk);
    busy_cycles = 0; done_cnt = 0; rden_cnt = 0;
    period_bad = 0; ss_bad = 0; rxv_bad = 0; last_rise = -1; bitn = 0;
    tx_bytes.delete(); rx_bytes.delete(); addr_q.delete();
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] l);
    @(negedge clk);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0; len = '0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (SS !== 1'b1)     begin errs++; $display("FAIL reset_ss: got %b expected 1", SS); end
    vecs++; if (SCLK !== 1'b0)   begin errs++; $display("FAIL reset_sclk: got %b expected 0", SCLK); end
    vecs++; if (MOSI !== 1'b0)   begin errs++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
    vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vecs++; if (done !== 1'b0)   begin errs++; $display("FAIL reset_done: got %b expected 0", done); end
    vecs++; if (rd_en !== 1'b0)  begin errs++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    vecs++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    vecs++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    vecs++; if (rd_addr !== 8'h00) begin errs++; $display("FAIL reset_rd_addr: got %h expected 00", rd_addr); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit ok;
    mem[0] = 8'hA5;
    miso_pat = 8'h00;
    clear_mon();
    pulse_start(8'd1);
    wait_idle(200, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL t1_timeout: busy still %b expected 0", busy); end
    vecs++; if (tx_bytes.size() != 1) begin errs++; $display("FAIL t1_nbytes: got %0d expected 1", tx_bytes.size()); end
    vecs++; if (tx_bytes.size() > 0 && tx_bytes[0] !== 8'hA5) begin errs++; $display("FAIL t1_mosi: got %h expected a5", tx_bytes[0]); end
    vecs++; if (ss_bad != 0) begin errs++; $display("FAIL t1_ss_low: got %0d bad rises expected 0", ss_bad); end
    vecs++; if (done_cnt != 1) begin errs++; $display("FAIL t1_done: got %0d pulses expected 1", done_cnt); end
    vecs++; if (busy_cycles != 36) begin errs++; $display("FAIL t1_frame_len: got %0d expected 36", busy_cycles); end
    @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t1_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_multi_byte();
    bit ok;
    logic [7:0] exp_b [3];
    logic [ADDR_W-1:0] exp_a [3];
    logic [7:0] got;
    exp_b = '{8'h33, 8'h22, 8'h11};
    exp_a = '{8'd2, 8'd1, 8'd0};
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    clear_mon();
    pulse_start(8'd3);
    wait_idle(400, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL t2_timeout: busy still %b expected 0", busy); end
    for (int i = 0; i < 3; i++) begin
      got = (i < addr_q.size()) ? addr_q[i] : 8'hxx;
      vecs++; if (got !== exp_a[i]) begin errs++; $display("FAIL t2_rd_addr[%0d]: got %h expected %h", i, got, exp_a[i]); end
      got = (i < tx_bytes.size()) ? tx_bytes[i] : 8'hxx;
      vecs++; if (got !== exp_b[i]) begin errs++; $display("FAIL t2_mosi[%0d]: got %h expected %h", i, got, exp_b[i]); end
    end
    vecs++; if (rden_cnt != 3) begin errs++; $display("FAIL t2_rd_count: got %0d expected 3", rden_cnt); end
    vecs++; if (period_bad != 0) begin errs++; $display("FAIL t2_sclk_period: got %0d bad periods expected 0", period_bad); end
    vecs++; if (busy_cycles != 100) begin errs++; $display("FAIL t2_frame_len: got %0d expected 100", busy_cycles); end
  endtask

  task automatic test_miso_capture();
    bit ok;
    logic [7:0] got;
    mem[0] = 8'h81; mem[1] = 8'h18;
    miso_pat = 8'h3C;
    clear_mon();
    pulse_start(8'd2);
    wait_idle(300, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL t3_timeout: busy still %b expected 0", busy); end
    vecs++; if (rx_bytes.size() != 2) begin errs++; $display("FAIL t3_rx_count: got %0d expected 2", rx_bytes.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx;
      vecs++; if (got !== 8'h3C) begin errs++; $display("FAIL t3_rx_data[%0d]: got %h expected 3c", i, got); end
    end
    vecs++; if (rxv_bad != 0) begin errs++; $display("FAIL t3_rx_latency: got %0d late pulses expected 0", rxv_bad); end
    vecs++; if (rx_data !== 8'h3C) begin errs++; $display("FAIL t3_rx_hold: got %h expected 3c", rx_data); end
    miso_pat = 8'h00;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [7:0] got;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    clear_mon();
    pulse_start(8'd128);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_bytes.size() >= 2) begin ok = 1'b1; break; end
    end
    vecs++; if (!ok) begin errs++; $display("FAIL t4_progress: got %0d bytes expected 2", tx_bytes.size()); end
    got = (tx_bytes.size() > 0) ? tx_bytes[0] : 8'hxx;
    vecs++; if (got !== 8'h25) begin errs++; $display("FAIL t4_first_byte: got %h expected 25", got); end
    got = (tx_bytes.size() > 1) ? tx_bytes[1] : 8'hxx;
    vecs++; if (got !== 8'h24) begin errs++; $display("FAIL t4_second_byte: got %h expected 24", got); end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    vecs++; if (SS !== 1'b1)   begin errs++; $display("FAIL t4_ss: got %b expected 1", SS); end
    vecs++; if (SCLK !== 1'b0) begin errs++; $display("FAIL t4_sclk: got %b expected 0", SCLK); end
    vecs++; if (MOSI !== 1'b0) begin errs++; $display("FAIL t4_mosi: got %b expected 0", MOSI); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t4_busy: got %b expected 0", busy); end
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    vecs++; if (done_cnt != 0) begin errs++; $display("FAIL t4_no_done: got %0d pulses expected 0", done_cnt); end
    mem[0] = 8'hC3; mem[1] = 8'h7E;
    clear_mon();
    pulse_start(8'd2);
    wait_idle(300, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL t4_restart_timeout: busy still %b expected 0", busy); end
    got = (tx_bytes.size() > 0) ? tx_bytes[0] : 8'hxx;
    vecs++; if (got !== 8'h7E) begin errs++; $display("FAIL t4_restart_b0: got %h expected 7e", got); end
    got = (tx_bytes.size() > 1) ? tx_bytes[1] : 8'hxx;
    vecs++; if (got !== 8'hC3) begin errs++; $display("FAIL t4_restart_b1: got %h expected c3", got); end
    vecs++; if (done_cnt != 1) begin errs++; $display("FAIL t4_restart_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_ignored_start();
    bit ok;
    logic [7:0] got;
    clear_mon();
    pulse_start(8'd0);
    repeat (10) @(negedge clk);
    vecs++; if (rden_cnt != 0) begin errs++; $display("FAIL t5_len0_rd_en: got %0d reads expected 0", rden_cnt); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t5_len0_busy: got %b expected 0", busy); end
    mem[0] = 8'h5A; mem[1] = 8'hF0;
    clear_mon();
    pulse_start(8'd2);
    repeat (10) @(negedge clk);
    pulse_start(8'd5);
    wait_idle(300, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL t5_timeout: busy still %b expected 0", busy); end
    vecs++; if (rden_cnt != 2) begin errs++; $display("FAIL t5_busy_rd_en: got %0d reads expected 2", rden_cnt); end
    got = (tx_bytes.size() > 0) ? tx_bytes[0] : 8'hxx;
    vecs++; if (got !== 8'hF0) begin errs++; $display("FAIL t5_b0: got %h expected f0", got); end
    got = (tx_bytes.size() > 1) ? tx_bytes[1] : 8'hxx;
    vecs++; if (got !== 8'h5A) begin errs++; $display("FAIL t5_b1: got %h expected 5a", got); end
    vecs++; if (busy_cycles != 68) begin errs++; $display("FAIL t5_frame_len: got %0d expected 68", busy_cycles); end
    vecs++; if (done_cnt != 1) begin errs++; $display("FAIL t5_done: got %0d pulses expected 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_miso_capture();
    test_reset_midframe();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
